// File: rtl/e2lp_led_controller_pkg.sv
// Shared definitions for the E2LP LED pattern engine: register addresses,
// mode codes and step-FSM state encodings.
package e2lp_led_controller_pkg;

  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_RATE    = 2'd2;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_STATIC    = 3'd0,
    S_BLINK_ON  = 3'd1,
    S_BLINK_OFF = 3'd2,
    S_CHASE     = 3'd3,
    S_BOUNCE_L  = 3'd4,
    S_BOUNCE_R  = 3'd5
  } state_t;

  // Every mode starts in a state that is currently showing the stored pattern.
  function automatic state_t entry_state(input mode_t mode);
    case (mode)
      MODE_BLINK:  entry_state = S_BLINK_ON;
      MODE_CHASE:  entry_state = S_CHASE;
      MODE_BOUNCE: entry_state = S_BOUNCE_L;
      default:     entry_state = S_STATIC;
    endcase
  endfunction

endpackage

// File: rtl/e2lp_led_tick_gen.sv
// Step generator: prescaler producing a base tick, followed by a rate counter
// that emits a one-cycle step on every (rate+1)-th tick.
module e2lp_led_tick_gen #(
  parameter int unsigned TICK_DIVISOR = 25_000_000,
  parameter int unsigned DIV_WIDTH    = 25
) (
  input  logic       system_clock,
  input  logic       system_reset,
  input  logic       clear,
  input  logic [7:0] rate,
  output logic       step
);

  localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(TICK_DIVISOR - 1);

  logic [DIV_WIDTH-1:0] presc_reg;
  logic [7:0]           rate_cnt_reg;
  logic                 tick;

  assign tick = (presc_reg == PRESC_LAST);
  assign step = tick && (rate_cnt_reg == rate);

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      presc_reg    <= '0;
      rate_cnt_reg <= '0;
    end else if (clear) begin
      presc_reg    <= '0;
      rate_cnt_reg <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick)
        rate_cnt_reg <= step ? 8'd0 : rate_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/e2lp_led_controller.sv
// LED pattern engine: CPU register file with ready handshake and a step FSM
// driving the LED bitmap plus a one-cycle Set strobe for the output stage.
module e2lp_led_controller
  import e2lp_led_controller_pkg::*;
#(
  parameter int unsigned TICK_DIVISOR = 25_000_000,
  parameter int unsigned DIV_WIDTH    = 25
) (
  input  logic       system_clock,
  input  logic       system_reset,
  input  logic       i_Write,
  input  logic [1:0] i_Address,
  input  logic [7:0] i_Data,
  output logic       o_Ready,
  output logic [7:0] o_Leds,
  output logic       o_Set
);

  logic [7:0] pattern_reg;
  mode_t      mode_reg;
  logic [7:0] rate_reg;
  logic       ready_reg;
  logic       started_reg;
  state_t     state_reg, state_next;
  logic [7:0] leds_reg, leds_next;
  logic       set_reg, set_next;

  logic accept, wr_pattern, wr_mode, wr_rate, clear, step;

  assign accept     = i_Write && ready_reg;
  assign wr_pattern = accept && (i_Address == ADDR_PATTERN);
  assign wr_mode    = accept && (i_Address == ADDR_MODE);
  assign wr_rate    = accept && (i_Address == ADDR_RATE);
  assign clear      = wr_pattern || wr_mode || wr_rate;

  e2lp_led_tick_gen #(
    .TICK_DIVISOR(TICK_DIVISOR),
    .DIV_WIDTH   (DIV_WIDTH)
  ) u_tick_gen (
    .system_clock(system_clock),
    .system_reset(system_reset),
    .clear       (clear),
    .rate        (rate_reg),
    .step        (step)
  );

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      pattern_reg <= '0;
      mode_reg    <= MODE_STATIC;
      rate_reg    <= '0;
      ready_reg   <= 1'b0;
      started_reg <= 1'b0;
      state_reg   <= S_STATIC;
      leds_reg    <= '0;
      set_reg     <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      ready_reg   <= !accept;
      if (wr_pattern) pattern_reg <= i_Data;
      if (wr_mode)    mode_reg    <= mode_t'(i_Data[1:0]);
      if (wr_rate)    rate_reg    <= i_Data;
      state_reg <= state_next;
      leds_reg  <= leds_next;
      set_reg   <= set_next;
    end
  end

  // Effective writes take priority over a coincident step, which is dropped.
  always_comb begin
    state_next = state_reg;
    leds_next  = leds_reg;
    set_next   = !started_reg;
    if (wr_pattern) begin
      leds_next  = i_Data;
      set_next   = 1'b1;
      state_next = entry_state(mode_reg);
    end else if (wr_mode) begin
      leds_next  = pattern_reg;
      set_next   = 1'b1;
      state_next = entry_state(mode_t'(i_Data[1:0]));
    end else if (!wr_rate && step) begin
      set_next = (state_reg != S_STATIC);
      case (state_reg)
        S_BLINK_ON: begin
          leds_next  = 8'h00;
          state_next = S_BLINK_OFF;
        end
        S_BLINK_OFF: begin
          leds_next  = pattern_reg;
          state_next = S_BLINK_ON;
        end
        S_CHASE: leds_next = {leds_reg[6:0], leds_reg[7]};
        S_BOUNCE_L: begin
          leds_next = {leds_reg[6:0], leds_reg[7]};
          if (leds_reg[6]) state_next = S_BOUNCE_R;
        end
        S_BOUNCE_R: begin
          leds_next = {leds_reg[0], leds_reg[7:1]};
          if (leds_reg[1]) state_next = S_BOUNCE_L;
        end
        default: set_next = 1'b0;
      endcase
    end
  end

  assign o_Ready = ready_reg;
  assign o_Leds  = leds_reg;
  assign o_Set   = set_reg;

endmodule

// File: tb/tb_e2lp_led_controller.sv
// Directed self-checking bench for e2lp_led_controller with a 4-cycle tick.
module tb_e2lp_led_controller;

  logic       system_clock;
  logic       system_reset;
  logic       i_Write;
  logic [1:0] i_Address;
  logic [7:0] i_Data;
  logic       o_Ready;
  logic [7:0] o_Leds;
  logic       o_Set;

  int tests = 0;
  int fails = 0;

  e2lp_led_controller #(
    .TICK_DIVISOR(4),
    .DIV_WIDTH   (3)
  ) dut (
    .system_clock(system_clock),
    .system_reset(system_reset),
    .i_Write     (i_Write),
    .i_Address   (i_Address),
    .i_Data      (i_Data),
    .o_Ready     (o_Ready),
    .o_Leds      (o_Leds),
    .o_Set       (o_Set)
  );

  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready, then holds i_Write for exactly one edge;
  // returns at the falling edge of the cycle following acceptance.
  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    int waited = 0;
    while (o_Ready !== 1'b1 && waited < 8) begin
      @(negedge system_clock);
      waited++;
    end
    chk1("ready_before_write", o_Ready, 1'b1);
    $display("[TB] write addr=%0d data=%h", addr, data);
    i_Write   = 1'b1;
    i_Address = addr;
    i_Data    = data;
    @(negedge system_clock);
    i_Write = 1'b0;
  endtask

  task automatic step_check(input string tag, input logic [7:0] exp, input int gap);
    int early = 0;
    repeat (gap - 1) begin
      @(negedge system_clock);
      if (o_Set === 1'b1) early++;
    end
    chk8({tag, "_early_set"}, 8'(early), 8'd0);
    @(negedge system_clock);
    chk8(tag, o_Leds, exp);
    chk1({tag, "_set"}, o_Set, 1'b1);
  endtask

  initial begin
    int quiet_sets;
    system_reset = 1'b1;
    i_Write      = 1'b0;
    i_Address    = 2'd0;
    i_Data       = 8'h00;

    // 1: reset release
    repeat (3) @(negedge system_clock);
    system_reset = 1'b0;
    chk8("rst_leds", o_Leds, 8'h00);
    chk1("rst_set", o_Set, 1'b0);
    chk1("rst_ready", o_Ready, 1'b0);
    @(negedge system_clock);
    chk1("rel_c1_set", o_Set, 1'b1);
    chk1("rel_c1_ready", o_Ready, 1'b1);
    chk8("rel_c1_leds", o_Leds, 8'h00);
    @(negedge system_clock);
    chk1("rel_c2_set", o_Set, 1'b0);
    chk1("rel_c2_ready", o_Ready, 1'b1);

    // 2: static pattern, ignored write, reserved address, quiet period
    do_write(2'd0, 8'hA5);
    chk8("static_leds", o_Leds, 8'hA5);
    chk1("static_set", o_Set, 1'b1);
    chk1("static_ready_low", o_Ready, 1'b0);
    i_Write   = 1'b1;
    i_Address = 2'd0;
    i_Data    = 8'hFF;
    @(negedge system_clock);
    i_Write = 1'b0;
    chk8("ignored_leds", o_Leds, 8'hA5);
    chk1("ignored_set", o_Set, 1'b0);
    chk1("ignored_ready", o_Ready, 1'b1);
    do_write(2'd3, 8'hFF);
    chk8("addr3_leds", o_Leds, 8'hA5);
    chk1("addr3_set", o_Set, 1'b0);
    chk1("addr3_ready_low", o_Ready, 1'b0);
    quiet_sets = 0;
    repeat (100) begin
      @(negedge system_clock);
      if (o_Set === 1'b1) quiet_sets++;
    end
    chk8("static_quiet_sets", 8'(quiet_sets), 8'd0);
    chk8("static_quiet_leds", o_Leds, 8'hA5);

    // 3: chase at rate 0
    do_write(2'd0, 8'h01);
    do_write(2'd2, 8'h00);
    chk1("rate_no_set", o_Set, 1'b0);
    chk8("rate_leds", o_Leds, 8'h01);
    do_write(2'd1, 8'h02);
    chk8("chase_entry", o_Leds, 8'h01);
    chk1("chase_entry_set", o_Set, 1'b1);
    step_check("chase_s1", 8'h02, 4);
    step_check("chase_s2", 8'h04, 4);
    step_check("chase_s3", 8'h08, 4);
    step_check("chase_s4", 8'h10, 4);
    step_check("chase_s5", 8'h20, 4);
    step_check("chase_s6", 8'h40, 4);
    step_check("chase_s7", 8'h80, 4);
    step_check("chase_wrap", 8'h01, 4);

    // 6: pattern write landing on a step edge restarts the step timing
    repeat (3) @(negedge system_clock);
    do_write(2'd0, 8'h3C);
    chk8("stepedge_leds", o_Leds, 8'h3C);
    chk1("stepedge_set", o_Set, 1'b1);
    step_check("stepedge_next", 8'h78, 4);

    // 6: reset in the middle of chase
    @(negedge system_clock);
    system_reset = 1'b1;
    #1;
    chk8("midrst_leds", o_Leds, 8'h00);
    chk1("midrst_set", o_Set, 1'b0);
    chk1("midrst_ready", o_Ready, 1'b0);
    @(negedge system_clock);
    system_reset = 1'b0;
    @(negedge system_clock);
    chk1("midrst_rel_set", o_Set, 1'b1);
    chk8("midrst_rel_leds", o_Leds, 8'h00);

    // 4: blink at rate 1 (8 cycles per step)
    do_write(2'd0, 8'hA5);
    do_write(2'd2, 8'h01);
    do_write(2'd1, 8'h01);
    chk8("blink_entry", o_Leds, 8'hA5);
    chk1("blink_entry_set", o_Set, 1'b1);
    step_check("blink_off1", 8'h00, 8);
    step_check("blink_on1", 8'hA5, 8);
    step_check("blink_off2", 8'h00, 8);
    step_check("blink_on2", 8'hA5, 8);

    // 5: bounce at rate 0
    do_write(2'd0, 8'h01);
    do_write(2'd2, 8'h00);
    do_write(2'd1, 8'h03);
    chk8("bounce_entry", o_Leds, 8'h01);
    step_check("bounce_l1", 8'h02, 4);
    step_check("bounce_l2", 8'h04, 4);
    step_check("bounce_l3", 8'h08, 4);
    step_check("bounce_l4", 8'h10, 4);
    step_check("bounce_l5", 8'h20, 4);
    step_check("bounce_l6", 8'h40, 4);
    step_check("bounce_l7", 8'h80, 4);
    step_check("bounce_r1", 8'h40, 4);
    step_check("bounce_r2", 8'h20, 4);
    step_check("bounce_r3", 8'h10, 4);
    step_check("bounce_r4", 8'h08, 4);
    step_check("bounce_r5", 8'h04, 4);
    step_check("bounce_r6", 8'h02, 4);
    step_check("bounce_r7", 8'h01, 4);
    step_check("bounce_turn", 8'h02, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
